memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 68 ++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: word-addressed data RAM with synchronous clear, registered
// load data, and one-cycle pass-through of write-back control, ALU result and destination.
module memory_stage #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg,
  output logic        pcsrc,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_out,
  output logic [4:0]  write_reg_out
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_BITS;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] index_p0;

  logic [1:0]        wb_p1;
  logic [DATA_W-1:0] read_data_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [4:0]        write_reg_p1;

  // Stage p0: branch resolution and address decode (byte offset and high bits dropped)
  assign pcsrc    = branch & zero;
  assign index_p0 = alu_result[ADDR_BITS+1:2];

  // Reset clears every word; the read below samples the pre-edge contents, so a
  // same-index read/write returns old data while the array takes the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (memwrite == 1'b1) begin
      mem[index_p0] <= write_data;
    end
  end

  // Stage p1: registered outputs toward write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p1        <= '0;
      read_data_p1 <= '0;
      alu_p1       <= '0;
      write_reg_p1 <= '0;
    end else begin
      wb_p1        <= wb;
      read_data_p1 <= (memread == 1'b1) ? mem[index_p0] : '0;
      alu_p1       <= alu_result;
      write_reg_p1 <= write_reg;
    end
  end

  assign wb_out        = wb_p1;
  assign read_data     = read_data_p1;
  assign alu_out       = alu_p1;
  assign write_reg_out = write_reg_p1;

endmodule
